bram_load_ctrl: RTL and testbench



---
 rtl/bram_load_ctrl_if.sv | 27 ++
 rtl/bram_load_ctrl.sv | 105 ++++++++++
 tb/tb_bram_load_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/bram_load_ctrl_if.sv
// Handshake and BRAM-port bundle for bram_load_ctrl.
// master = the controller, slave = upstream/consumer/BRAM environment.
interface bram_load_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr_in;
  logic                  addr_valid;
  logic                  addr_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;
  logic                  loadEn;
  logic [ADDR_WIDTH-1:0] loadAddr;
  logic [DATA_WIDTH-1:0] loadData;
  logic                  busy;

  modport master (
    input  addr_in, addr_valid, data_ready, loadData,
    output addr_ready, data_out, data_valid, loadEn, loadAddr, busy
  );

  modport slave (
    output addr_in, addr_valid, data_ready, loadData,
    input  addr_ready, data_out, data_valid, loadEn, loadAddr, busy
  );
endinterface

// File: rtl/bram_load_ctrl.sv
// Credit-based load front-end for a fixed-latency BRAM: issues reads,
// tracks them in flight and returns the data in order through a small FIFO.
module bram_load_ctrl #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 3
) (
  input  logic             clk,
  input  logic             rst,
  bram_load_ctrl_if.master bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  logic [CNT_W-1:0]        count_reg, count_next;
  logic [CNT_W-1:0]        occ_reg, occ_next;
  logic [PTR_W-1:0]        wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]        rd_ptr_reg, rd_ptr_next;
  logic [READ_LATENCY-1:0] inflight_reg;
  logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   load_addr;

  logic credit_ok;
  logic issue;
  logic push;
  logic pop;
  logic data_valid;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign credit_ok  = (count_reg < DEPTH_C);
  assign issue      = bus.addr_valid && credit_ok;
  assign push       = inflight_reg[READ_LATENCY-1];
  assign data_valid = (occ_reg != '0);
  assign pop        = data_valid && bus.data_ready;
  assign load_addr  = bus.addr_in;

  // State is already cleared while rst is low; only the visible handshake needs masking.
  assign bus.addr_ready = rst && credit_ok;
  assign bus.loadEn     = rst && issue;
  assign bus.loadAddr   = load_addr;
  assign bus.data_valid = data_valid;
  assign bus.data_out   = fifo_mem[rd_ptr_reg];
  assign bus.busy       = (count_reg != '0);

  always_comb begin
    count_next  = count_reg;
    occ_next    = occ_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    case ({issue, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    case ({push, pop})
      2'b10:   occ_next = occ_reg + 1'b1;
      2'b01:   occ_next = occ_reg - 1'b1;
      default: occ_next = occ_reg;
    endcase
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg  <= '0;
      occ_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      count_reg  <= count_next;
      occ_reg    <= occ_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Tap READ_LATENCY-1 marks the cycle in which loadData holds the word for that issue.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight_reg <= '0;
        else      inflight_reg <= issue;
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) inflight_reg <= '0;
        else      inflight_reg <= {inflight_reg[READ_LATENCY-2:0], issue};
      end
    end
  endgenerate

  // Credits guarantee the write slot never aliases the unpopped head entry.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= bus.loadData;
  end

endmodule

// File: tb/tb_bram_load_ctrl.sv
// Directed bench for bram_load_ctrl: default config (latency 1, depth 3)
// plus a latency-3 / depth-5 instance, each behind a behavioural BRAM.
module tb_bram_load_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] t_addr [2];
  logic        t_av   [2];
  logic        t_dr   [2];

  logic        o_en [2], o_ar [2], o_dv [2], o_busy [2];
  logic [31:0] o_la [2], o_do [2];

  bram_load_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_a ();
  bram_load_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus_b ();

  bram_load_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1), .FIFO_DEPTH(3))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a.master));
  bram_load_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .READ_LATENCY(3), .FIFO_DEPTH(5))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b.master));

  assign bus_a.addr_in    = t_addr[0];
  assign bus_a.addr_valid = t_av[0];
  assign bus_a.data_ready = t_dr[0];
  assign bus_b.addr_in    = t_addr[1];
  assign bus_b.addr_valid = t_av[1];
  assign bus_b.data_ready = t_dr[1];

  assign o_en[0] = bus_a.loadEn;     assign o_en[1] = bus_b.loadEn;
  assign o_ar[0] = bus_a.addr_ready; assign o_ar[1] = bus_b.addr_ready;
  assign o_dv[0] = bus_a.data_valid; assign o_dv[1] = bus_b.data_valid;
  assign o_busy[0] = bus_a.busy;     assign o_busy[1] = bus_b.busy;
  assign o_la[0] = bus_a.loadAddr;   assign o_la[1] = bus_b.loadAddr;
  assign o_do[0] = bus_a.data_out;   assign o_do[1] = bus_b.data_out;

  function automatic logic [31:0] mem_val(input logic [31:0] ad);
    return (ad == 32'h10) ? 32'hDEADBEEF : ad + 32'h100;
  endfunction

  // BRAM models; filler words outside a read slot expose latency errors.
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [3];
  always @(posedge clk) begin
    pipe_a   <= bus_a.loadEn ? mem_val(bus_a.loadAddr) : 32'hBAD0BAD0;
    pipe_b[0] <= bus_b.loadEn ? mem_val(bus_b.loadAddr) : 32'hBAD1BAD1;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign bus_a.loadData = pipe_a;
  assign bus_b.loadData = pipe_b[2];

  // Transaction monitor, sampled mid-cycle.
  int          cyc;
  int          n_iss [2];
  int          n_pop [2];
  logic [31:0] got_q    [2][$];
  int          got_cyc  [2][$];
  int          iss_cyc  [2][$];
  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (o_en[k]) begin
        iss_cyc[k].push_back(cyc);
        n_iss[k] <= n_iss[k] + 1;
      end
      if (o_dv[k] && t_dr[k]) begin
        got_q[k].push_back(o_do[k]);
        got_cyc[k].push_back(cyc);
        n_pop[k] <= n_pop[k] + 1;
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  // mode 0: ready always 1, mode 1: random ready, mode 2: ready 0 for `hold` cycles.
  task automatic run_loads(input int k, input logic [31:0] base, input int n,
                           input int mode, input int hold,
                           output int stalls, output int maxo, output int sent_snap,
                           output logic rdy_snap, output logic [31:0] dout_snap,
                           output int gbase, output int ibase);
    int sent, cyc_l, pop0, iss0, outs;
    sent = 0; cyc_l = 0; stalls = 0; maxo = 0;
    sent_snap = 0; rdy_snap = 1'b0; dout_snap = '0;
    pop0 = n_pop[k]; iss0 = n_iss[k];
    gbase = got_q[k].size(); ibase = iss_cyc[k].size();
    while ((sent < n || (n_pop[k] - pop0) < n) && cyc_l < 300) begin
      @(posedge clk); #1;
      case (mode)
        0:       t_dr[k] = 1'b1;
        1:       t_dr[k] = 1'($urandom_range(0, 1));
        default: t_dr[k] = (cyc_l >= hold);
      endcase
      t_av[k]   = (sent < n);
      t_addr[k] = base + 32'(sent);
      #1;
      if (t_av[k] && !o_ar[k]) stalls++;
      if (o_en[k]) sent++;
      if (mode == 2 && cyc_l == hold - 1) begin
        sent_snap = sent;
        rdy_snap  = o_ar[k];
        dout_snap = o_do[k];
      end
      outs = (n_iss[k] - iss0) - (n_pop[k] - pop0);
      if (outs > maxo) maxo = outs;
      cyc_l++;
    end
    t_av[k] = 1'b0;
    check("run_timeout", 64'(cyc_l < 300), 64'd1);
    repeat (3) @(posedge clk);
    #2;
    check("run_word_count", 64'(got_q[k].size() - gbase), 64'(n));
    if (got_q[k].size() - gbase == n)
      for (int i = 0; i < n; i++)
        check($sformatf("run_data_%0d", i), 64'(got_q[k][gbase + i]),
              64'(mem_val(base + 32'(i))));
  endtask

  int          stalls, maxo, sent_snap, gbase, ibase, gsize;
  logic        rdy_snap;
  logic [31:0] dout_snap;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      t_addr[k] = '0; t_av[k] = 1'b0; t_dr[k] = 1'b0;
    end
    t_av[0] = 1'b1; t_addr[0] = 32'h10;
    repeat (2) @(posedge clk);
    #2;
    check("rst_addr_ready", 64'(o_ar[0]), 64'd0);
    check("rst_loadEn", 64'(o_en[0]), 64'd0);
    check("rst_data_valid", 64'(o_dv[0]), 64'd0);
    check("rst_busy", 64'(o_busy[0]), 64'd0);
    check("rst_loadAddr_pass", 64'(o_la[0]), 64'h10);
    t_av[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rel_addr_ready_a", 64'(o_ar[0]), 64'd1);
    check("rel_addr_ready_b", 64'(o_ar[1]), 64'd1);

    // Single load at 0x10.
    @(posedge clk); #1;
    t_addr[0] = 32'h10; t_av[0] = 1'b1; t_dr[0] = 1'b1;
    #1;
    check("single_loadEn", 64'(o_en[0]), 64'd1);
    check("single_loadAddr", 64'(o_la[0]), 64'h10);
    @(posedge clk); #1;
    t_av[0] = 1'b0;
    #1;
    check("single_loadEn_drop", 64'(o_en[0]), 64'd0);
    check("single_dv_early", 64'(o_dv[0]), 64'd0);
    check("single_busy", 64'(o_busy[0]), 64'd1);
    @(posedge clk); #2;
    check("single_dv", 64'(o_dv[0]), 64'd1);
    check("single_data", 64'(o_do[0]), 64'hDEADBEEF);
    @(posedge clk); #2;
    check("single_dv_after_pop", 64'(o_dv[0]), 64'd0);
    check("single_busy_after_pop", 64'(o_busy[0]), 64'd0);

    // Streaming, 8 back-to-back.
    run_loads(0, 32'h0, 8, 0, 0, stalls, maxo, sent_snap, rdy_snap, dout_snap, gbase, ibase);
    check("stream_stalls", 64'(stalls), 64'd0);
    if (got_q[0].size() >= gbase + 8 && iss_cyc[0].size() > ibase) begin
      check("stream_consecutive", 64'(got_cyc[0][gbase + 7] - got_cyc[0][gbase]), 64'd7);
      check("stream_latency", 64'(got_cyc[0][gbase] - iss_cyc[0][ibase]), 64'd2);
    end

    // Back-pressure: ready low for 6 cycles while offering 5 addresses.
    run_loads(0, 32'h20, 5, 2, 6, stalls, maxo, sent_snap, rdy_snap, dout_snap, gbase, ibase);
    check("bp_issued", 64'(sent_snap), 64'd3);
    check("bp_addr_ready", 64'(rdy_snap), 64'd0);
    check("bp_head_stable", 64'(dout_snap), 64'h120);
    check("bp_max_credit", 64'(maxo), 64'd3);

    // Random ready, 10 loads: several pointer laps at depth 3.
    run_loads(0, 32'h40, 10, 1, 0, stalls, maxo, sent_snap, rdy_snap, dout_snap, gbase, ibase);
    check("rand_credit_bound", 64'(maxo <= 3), 64'd1);

    // Reset with a full credit count.
    t_dr[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      t_addr[0] = 32'h70 + 32'(i); t_av[0] = 1'b1;
    end
    @(posedge clk); #2;
    check("pre_rst_busy", 64'(o_busy[0]), 64'd1);
    check("pre_rst_dv", 64'(o_dv[0]), 64'd1);
    rst = 1'b0;
    #1;
    check("async_rst_addr_ready", 64'(o_ar[0]), 64'd0);
    check("async_rst_loadEn", 64'(o_en[0]), 64'd0);
    check("async_rst_dv", 64'(o_dv[0]), 64'd0);
    check("async_rst_busy", 64'(o_busy[0]), 64'd0);
    t_av[0] = 1'b0; t_dr[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    gsize = got_q[0].size();
    repeat (4) @(posedge clk);
    #2;
    check("post_rst_no_stale_dv", 64'(o_dv[0]), 64'd0);
    check("post_rst_no_stale_word", 64'(got_q[0].size()), 64'(gsize));
    run_loads(0, 32'h50, 1, 0, 0, stalls, maxo, sent_snap, rdy_snap, dout_snap, gbase, ibase);

    // Latency 3, depth 5 instance: 10 streaming loads.
    run_loads(1, 32'h60, 10, 0, 0, stalls, maxo, sent_snap, rdy_snap, dout_snap, gbase, ibase);
    check("l3_stalls", 64'(stalls), 64'd0);
    check("l3_credit_bound", 64'(maxo <= 5), 64'd1);
    if (got_q[1].size() >= gbase + 10 && iss_cyc[1].size() > ibase) begin
      check("l3_latency", 64'(got_cyc[1][gbase] - iss_cyc[1][ibase]), 64'd4);
      check("l3_consecutive", 64'(got_cyc[1][gbase + 9] - got_cyc[1][gbase]), 64'd9);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
